// File: rtl/muldiv_pkg.sv
// muldiv_pkg
// Shared types and constants for the iterative RV64M multiply/divide unit.
// Holds the funct3 operation encodings, the FSM state type, the default
// datapath width and the width of the iteration counter.

package muldiv_pkg;

    localparam int XLEN_DEFAULT = 64;
    localparam int WORD_W       = 32;
    // Wide enough to hold an iteration count of up to 64.
    localparam int CNT_W        = 7;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_DONE
    } state_e;

endpackage

// File: rtl/exe_muldiv_if.sv
// exe_muldiv_if
// Request/response bundle between the execute stage and the mul/div unit.
//   in_valid/in_ready   : request handshake (op, is_word, a, b)
//   flush               : kill in-flight or pending work
//   out_valid/out_ready : response handshake (result)
// The master modport is the requester side, the slave modport is the unit.

interface exe_muldiv_if
    import muldiv_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
);
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      op;
    logic            is_word;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;

    modport master (
        output in_valid, op, is_word, a, b, flush, out_ready,
        input  in_ready, out_valid, result
    );

    modport slave (
        input  in_valid, op, is_word, a, b, flush, out_ready,
        output in_ready, out_valid, result
    );
endinterface

// File: rtl/muldiv_step.sv
// muldiv_step
// One combinational iteration on the {hi, lo} working register pair.
//   is_div_i : 0 = shift-add multiply step, 1 = restoring divide step
//   hi_i     : product high half / partial remainder
//   lo_i     : multiplier bits still to consume / dividend bits + quotient
//   m_i      : multiplicand or divisor magnitude
//   hi_o/lo_o: register pair after the step

module muldiv_step #(
    parameter int XLEN = 64
) (
    input  logic            is_div_i,
    input  logic [XLEN-1:0] hi_i,
    input  logic [XLEN-1:0] lo_i,
    input  logic [XLEN-1:0] m_i,
    output logic [XLEN-1:0] hi_o,
    output logic [XLEN-1:0] lo_o
);

    logic [XLEN:0] mul_sum;
    logic [XLEN:0] div_shift;
    logic [XLEN:0] div_diff;
    logic          div_fits;

    // Multiply: add the multiplicand when the next multiplier bit is set, then
    // shift the whole {carry, hi, lo} right so the product grows from the top.
    // Divide: bring the next dividend bit into the remainder and keep the
    // trial subtraction only when it does not go negative.
    always_comb begin
        mul_sum   = {1'b0, hi_i} + (lo_i[0] ? {1'b0, m_i} : '0);
        div_shift = {hi_i, lo_i[XLEN-1]};
        div_diff  = div_shift - {1'b0, m_i};
        div_fits  = ~div_diff[XLEN];
        if (is_div_i) begin
            hi_o = div_fits ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
            lo_o = {lo_i[XLEN-2:0], div_fits};
        end else begin
            hi_o = mul_sum[XLEN:1];
            lo_o = {mul_sum[0], lo_i[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/exe_muldiv.sv
// exe_muldiv
// Iterative M-extension multiply/divide unit for the execute stage.
//   clk : rising-edge clock
//   rst : synchronous, active-high reset
//   bus : slave side of exe_muldiv_if (request, flush, registered response)
// One operation at a time; in_ready is low while busy so the pipeline can
// stall. Normal operations take one cycle per operand bit, divide-by-zero and
// signed overflow finish in a single cycle.

module exe_muldiv
    import muldiv_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input logic          clk,
    input logic          rst,
    exe_muldiv_if.slave  bus
);

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        return XLEN'($signed(v));
    endfunction

    function automatic logic [XLEN-1:0] zext32(input logic [31:0] v);
        return XLEN'(v);
    endfunction

    state_e           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [XLEN-1:0]  hi_q, hi_d;
    logic [XLEN-1:0]  lo_q, lo_d;
    logic [XLEN-1:0]  m_q, m_d;
    op_e              op_q, op_d;
    logic             word_q, word_d;
    logic             div_q, div_d;
    logic             sa_q, sa_d;
    logic             sb_q, sb_d;
    logic [XLEN-1:0]  result_q, result_d;

    op_e              op_in;
    logic             mulh_in, div_in, rem_in, word_in, sgn_a_in, sgn_b_in;
    logic [XLEN-1:0]  a_ext, b_ext, a_mag, b_mag, dividend_val, min_neg;
    logic             sa_in, sb_in, b_zero, div_ovf;
    logic [XLEN-1:0]  special_res;

    logic [XLEN-1:0]   step_hi, step_lo;
    logic [2*XLEN-1:0] prod_raw, prod_w, prod_s;
    logic [XLEN-1:0]   quot_s, rem_s, sel_res, final_res;

    muldiv_step #(.XLEN(XLEN)) u_step (
        .is_div_i (div_q),
        .hi_i     (hi_q),
        .lo_i     (lo_q),
        .m_i      (m_q),
        .hi_o     (step_hi),
        .lo_o     (step_lo)
    );

    // Request decode: word forms exist only for MUL and the divides on a
    // 64-bit datapath. Operands are extended to XLEN (signed or unsigned as
    // the op requires) before taking magnitudes, so the datapath never needs
    // to know the word width except for alignment and the final extension.
    always_comb begin
        op_in    = op_e'(bus.op);
        mulh_in  = op_in inside {OP_MULH, OP_MULHSU, OP_MULHU};
        div_in   = op_in inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
        rem_in   = op_in inside {OP_REM, OP_REMU};
        word_in  = (XLEN == 64) && bus.is_word && !mulh_in;
        sgn_a_in = op_in inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
        sgn_b_in = op_in inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};

        if (word_in) begin
            a_ext = sgn_a_in ? sext32(bus.a[31:0]) : zext32(bus.a[31:0]);
            b_ext = sgn_b_in ? sext32(bus.b[31:0]) : zext32(bus.b[31:0]);
            dividend_val = sext32(bus.a[31:0]);
            min_neg      = sext32(32'h8000_0000);
        end else begin
            a_ext = bus.a;
            b_ext = bus.b;
            dividend_val = bus.a;
            min_neg      = {1'b1, {(XLEN-1){1'b0}}};
        end

        sa_in  = sgn_a_in && a_ext[XLEN-1];
        sb_in  = sgn_b_in && b_ext[XLEN-1];
        a_mag  = sa_in ? -a_ext : a_ext;
        b_mag  = sb_in ? -b_ext : b_ext;
        b_zero = (b_ext == '0);
        div_ovf = sgn_b_in && (a_ext == min_neg) && (b_ext == '1);

        special_res = '0;
        if (b_zero) begin
            special_res = rem_in ? dividend_val : '1;
        end else if (div_ovf) begin
            special_res = rem_in ? '0 : dividend_val;
        end
    end

    // Result formation from the final step: word multiplies leave the 64-bit
    // product 32 places up in the register pair, so realign before negating.
    always_comb begin
        prod_raw = {step_hi, step_lo};
        prod_w   = word_q ? (prod_raw >> (XLEN - WORD_W)) : prod_raw;
        prod_s   = (sa_q ^ sb_q) ? -prod_w : prod_w;
        quot_s   = (sa_q ^ sb_q) ? -step_lo : step_lo;
        rem_s    = sa_q ? -step_hi : step_hi;
        unique case (op_q)
            OP_MUL:                        sel_res = prod_s[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU:  sel_res = prod_s[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:               sel_res = quot_s;
            default:                       sel_res = rem_s;
        endcase
        final_res = word_q ? sext32(sel_res[31:0]) : sel_res;
    end

    // Next-state logic. Flush wins over everything and also drops a request
    // arriving in the same cycle. The last CALC step loads the result
    // directly, so DONE follows the W-th step without an extra cycle.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        m_d      = m_q;
        op_d     = op_q;
        word_d   = word_q;
        div_d    = div_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        result_d = result_q;

        if (bus.flush) begin
            state_d = ST_IDLE;
            count_d = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        op_d   = op_in;
                        word_d = word_in;
                        div_d  = div_in;
                        sa_d   = sa_in;
                        sb_d   = sb_in;
                        hi_d   = '0;
                        m_d    = b_mag;
                        // Dividend is left-aligned so its top bit is always lo[XLEN-1].
                        lo_d   = (div_in && word_in) ? (a_mag << (XLEN - WORD_W)) : a_mag;
                        if (div_in && (b_zero || div_ovf)) begin
                            result_d = special_res;
                            count_d  = '0;
                            state_d  = ST_DONE;
                        end else begin
                            count_d = word_in ? CNT_W'(WORD_W) : CNT_W'(XLEN);
                            state_d = ST_CALC;
                        end
                    end
                end
                ST_CALC: begin
                    hi_d    = step_hi;
                    lo_d    = step_lo;
                    count_d = count_q - CNT_W'(1);
                    if (count_q == CNT_W'(1)) begin
                        result_d = final_res;
                        state_d  = ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            count_q  <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            m_q      <= '0;
            op_q     <= OP_MUL;
            word_q   <= 1'b0;
            div_q    <= 1'b0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            m_q      <= m_d;
            op_q     <= op_d;
            word_q   <= word_d;
            div_q    <= div_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            result_q <= result_d;
        end
    end

    assign bus.in_ready  = (state_q == ST_IDLE);
    assign bus.out_valid = (state_q == ST_DONE);
    assign bus.result    = result_q;

endmodule
